// File: rtl/uart_alu_frame_parser_pkg.sv
// Shared types and constants for the UART ALU frame parser.
// The optional UART_FRAME_CHECKSUM_EN build uses WAIT_CHK and ERR_CHK.
package uart_alu_frame_parser_pkg;

  typedef enum logic [2:0] {
    WAIT_HDR,
    WAIT_A,
    WAIT_B,
    WAIT_CHK,
    ISSUE
  } parser_state_t;

  localparam logic [3:0] SYNC_NIB = 4'hA;

  localparam logic [2:0] ERR_SYNC = 3'd0;
  localparam logic [2:0] ERR_LINE = 3'd1;
  localparam logic [2:0] ERR_TOUT = 3'd2;
  localparam logic [2:0] ERR_OVR  = 3'd3;
  localparam logic [2:0] ERR_CHK  = 3'd4;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle timer: saturating counter that flags expiry while running.
// Cleared whenever clr is high; never wraps past TIMEOUT_CYC-1.
module uart_frame_timer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_reg;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (run && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = run && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/uart_alu_frame_parser.sv
// Assembles header/A/B byte frames from the UART receiver into ALU commands.
// Define UART_FRAME_CHECKSUM_EN to require a 4th byte equal to hdr^A^B.
module uart_alu_frame_parser
  import uart_alu_frame_parser_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FUNC_W      = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic [FUNC_W-1:0] alu_fun,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_vld,
  input  logic              alu_rdy,
  output logic              busy,
  output logic              err_vld,
  output logic [2:0]        err_code
);

  parser_state_t     state_reg, state_next;
  logic [FUNC_W-1:0] fun_reg, fun_next;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic              vld_reg, vld_next;
  logic              busy_reg, busy_next;
  logic              err_vld_reg, err_vld_next;
  logic [2:0]        err_code_reg, err_code_next;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] chk_reg, chk_next;
`endif

  logic handshake;
  logic tmr_run;
  logic tmr_clr;
  logic tmr_expire;

  assign handshake = (state_reg == ISSUE) && alu_rdy;
  assign tmr_run   = (state_reg == WAIT_A) || (state_reg == WAIT_B) || (state_reg == WAIT_CHK);
  assign tmr_clr   = !tmr_run || (rx_valid && !rx_err);

  uart_frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .CLK   (CLK),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .run   (tmr_run),
    .expire(tmr_expire)
  );

  always_comb begin
    state_next    = state_reg;
    fun_next      = fun_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    err_vld_next  = 1'b0;
    err_code_next = err_code_reg;
`ifdef UART_FRAME_CHECKSUM_EN
    chk_next      = chk_reg;
`endif

    if (handshake) begin
      state_next = WAIT_HDR;
    end

    // Error sources are mutually exclusive below except the line error,
    // which is checked first and suppresses the byte.
    if (rx_err) begin
      err_vld_next  = 1'b1;
      err_code_next = ERR_LINE;
      if (state_reg != ISSUE) begin
        state_next = WAIT_HDR;
      end
    end else if (rx_valid && (state_reg == ISSUE) && !alu_rdy) begin
      err_vld_next  = 1'b1;
      err_code_next = ERR_OVR;
    end else if (rx_valid && ((state_reg == WAIT_HDR) || (state_reg == ISSUE))) begin
      if (rx_data[DATA_W-1 -: 4] == SYNC_NIB) begin
        fun_next   = rx_data[FUNC_W-1:0];
        state_next = WAIT_A;
`ifdef UART_FRAME_CHECKSUM_EN
        chk_next   = rx_data;
`endif
      end else begin
        err_vld_next  = 1'b1;
        err_code_next = ERR_SYNC;
      end
    end else if (rx_valid) begin
      case (state_reg)
        WAIT_A: begin
          a_next     = rx_data;
          state_next = WAIT_B;
`ifdef UART_FRAME_CHECKSUM_EN
          chk_next   = chk_reg ^ rx_data;
`endif
        end
        WAIT_B: begin
          b_next = rx_data;
`ifdef UART_FRAME_CHECKSUM_EN
          chk_next   = chk_reg ^ rx_data;
          state_next = WAIT_CHK;
`else
          state_next = ISSUE;
`endif
        end
`ifdef UART_FRAME_CHECKSUM_EN
        WAIT_CHK: begin
          if (rx_data == chk_reg) begin
            state_next = ISSUE;
          end else begin
            err_vld_next  = 1'b1;
            err_code_next = ERR_CHK;
            state_next    = WAIT_HDR;
          end
        end
`endif
        default: ;
      endcase
    end else if (tmr_expire) begin
      err_vld_next  = 1'b1;
      err_code_next = ERR_TOUT;
      state_next    = WAIT_HDR;
    end

    vld_next  = (state_next == ISSUE);
    busy_next = (state_next != WAIT_HDR);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= WAIT_HDR;
      fun_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      vld_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      err_vld_reg  <= 1'b0;
      err_code_reg <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      fun_reg      <= fun_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      vld_reg      <= vld_next;
      busy_reg     <= busy_next;
      err_vld_reg  <= err_vld_next;
      err_code_reg <= err_code_next;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_reg      <= chk_next;
`endif
    end
  end

  assign alu_fun  = fun_reg;
  assign alu_a    = a_reg;
  assign alu_b    = b_reg;
  assign alu_vld  = vld_reg;
  assign busy     = busy_reg;
  assign err_vld  = err_vld_reg;
  assign err_code = err_code_reg;

endmodule
